psg_ecfs_lvdcdc_sd_adc_dec: RTL
===============================

# psg_ecfs_lvdcdc_sd_adc_dec

Decimation and comb (differentiator) half of the Sinc3 sigma-delta ADC filter. It samples the 22-bit third-stage integrator word from the Sinc3 integrator block once every R clk_adc cycles. It then applies three pipelined first-difference stages, all computed modulo 2^22. The result is a raw filtered sample plus a 16-bit normalized sample, each marked with a one-cycle valid strobe, for the current/voltage feedback path.

## Interface
Parameters:
- DATA_W, 22, integrator/comb datapath width. It is fixed at 22, which is enough for R=128.
- SETTLE, 3, number of decimated captures suppressed after reset, sync or a rate change.

Ports:
- clk_adc  in  1  ADC bit clock. This is the only clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- cn_in  in  22  integrator output word (clk_adc domain).
- dec_sel  in  2  decimation select: 0→R=32, 1→R=64, 2→R=128, 3→R=128.
- dec_sync  in  1  single-cycle pulse; restarts the decimation window (multi-channel alignment).
- data_raw  out  22  unsigned comb output, range 0..R^3.
- data_norm  out  16  data_raw scaled to R=128 full scale, saturated.
- data_valid  out  1  one-cycle strobe; data_raw/data_norm are valid in that cycle and are held until the next strobe.

## Operation
- Decimation counter cnt (7 bits) counts 0..R-1 and wraps to 0. When cnt==R-1, a capture strobe cap occurs: x_reg <= cn_in.
- Active rate R_act (k = log2 R_act ∈ {5,6,7}):
  - dec_sel is loaded into R_act only on the cycle cnt wraps, or on dec_sync.
  - Changes to dec_sel at any other time have no effect until the next wrap.
- dec_sync:
  - Forces cnt <= 0 and loads R_act from dec_sel.
  - The sync cycle is window cycle 0.
  - If dec_sync coincides with cnt==R-1, sync wins and no capture occurs.
- Comb pipeline, advanced only by cap and its delayed copies cap_d1/cap_d2; all subtractions are unsigned modulo 2^22, with wrap of cn_in tolerated:
  - cycle of cap+1: c1 <= x_reg − x_prev, and x_prev <= x_reg.
  - cap+2: c2 <= c1 − c1_prev, and c1_prev <= c1.
  - cap+3: c3 <= c2 − c2_prev, and c2_prev <= c2. data_raw <= c3 result; data_valid pulses.
- Normalization: s = data_raw << (21 − 3k), truncated to 22 bits. data_norm = (s[21:5] > 0xFFFF) ? 0xFFFF : s[20:5].
- Settling:
  - settle_cnt is cleared by reset, by dec_sync, and by a wrap that changes R_act.
  - It increments on each cap up to SETTLE.
  - data_valid is asserted only for captures arriving when settle_cnt==SETTLE. While suppressed, the pipeline still runs but data_raw/data_norm do not update.
- Reset (asynchronous, any time including mid-pipeline):
  - cnt, x_reg, x_prev, c1, c1_prev, c2, c2_prev, data_raw, data_norm, data_valid, and settle_cnt go to 0.
  - R_act resets to R=128.
  - Pipeline delay flags are cleared.

## Timing
- Capture to data_valid: 3 cycles (cap at T, valid at T+3). data_raw and data_norm update in the same cycle as data_valid.
- Strobe period is R_act cycles. Consecutive strobes never overlap because R ≥ 32 > pipeline depth.
- First data_valid after reset: the 4th capture (cycle 4R−1 counting from the reset release edge) plus 3, i.e. cycle 4R+2.
- After dec_sync: same timing, counted from the sync cycle.
- A rate change at a wrap takes effect for the window starting at that wrap. Outputs resume after 4 captures at the new rate.
- data_valid is never asserted for two consecutive cycles.

## Test plan
- Constant 1 bitstream, dec_sel=0 (R=32), integrator feeding cn_in → after settle: data_raw=32768 on every strobe, data_norm=0xFFFF, strobe every 32 cycles.
- Alternating 1/0 bitstream, dec_sel=2 (R=128) → data_raw=1048576, data_norm=0x8000. All-zero stream → data_raw=0, data_norm=0.
- Long constant-1 run at R=128 for more than 2^23 cycles, so cn_in wraps many times → data_raw remains 2097152 and data_norm=0xFFFF with no glitch at the wrap.
- dec_sel 2→1 applied mid-window → old rate is held to the wrap; no valid for 4 captures; then strobes every 64 cycles with data_raw=262144 for a constant-1 stream.
- dec_sync pulse at cnt=50, and separately coincident with cnt==R−1 → no capture on the sync cycle; next capture at sync+R−1; first valid 4R+2 cycles after sync.
- reset_n asserted 1 cycle after a capture (pipeline mid-flight) → all outputs are 0 immediately; no stray data_valid after release; first valid at cycle 4R+2.

Source files
------------

// File: rtl/psg_ecfs_lvdcdc_sd_adc_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : psg_ecfs_lvdcdc_sd_adc_dec
//  Purpose  : Sinc3 decimator/comb half. Samples the third-stage integrator
//             word once per R clk_adc cycles, applies three modulo-2^22
//             first-difference stages and emits a raw and a 16-bit
//             normalised sample with a one-cycle valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module psg_ecfs_lvdcdc_sd_adc_dec #(
  parameter int DATA_W = 22,
  parameter int SETTLE = 3
) (
  input  logic              clk_adc,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] cn_in,
  input  logic [1:0]        dec_sel,
  input  logic              dec_sync,
  output logic [DATA_W-1:0] data_raw,
  output logic [15:0]       data_norm,
  output logic              data_valid
);

  localparam int SETTLE_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);

  // Rate code: 0 -> R=32, 1 -> R=64, 2 -> R=128 (dec_sel 3 aliases to 128)
  function automatic logic [1:0] sel_to_code(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd2 : sel;
  endfunction

  // Last window cycle (R-1) for a rate code
  function automatic logic [6:0] code_to_last(input logic [1:0] code);
    case (code)
      2'd0:    return 7'd31;
      2'd1:    return 7'd63;
      default: return 7'd127;
    endcase
  endfunction

  // Left shift that scales R^3 full scale to the R=128 full scale (21 - 3k)
  function automatic logic [2:0] code_to_shift(input logic [1:0] code);
    case (code)
      2'd0:    return 3'd6;
      2'd1:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  logic [6:0]          cnt_q, cnt_d;
  logic [1:0]          r_act_q, r_act_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DATA_W-1:0]   x_reg_q, x_reg_d;
  logic [DATA_W-1:0]   x_prev_q, x_prev_d;
  logic [DATA_W-1:0]   c1_q, c1_d;
  logic [DATA_W-1:0]   c1_prev_q, c1_prev_d;
  logic [DATA_W-1:0]   c2_q, c2_d;
  logic [DATA_W-1:0]   c2_prev_q, c2_prev_d;
  logic                cap_d1_q, cap_d1_d;
  logic                cap_d2_q, cap_d2_d;
  logic                cap_d3_q, cap_d3_d;
  logic                cap_ok_q, cap_ok_d;
  logic [2:0]          cap_shift_q, cap_shift_d;
  logic [DATA_W-1:0]   data_raw_q, data_raw_d;
  logic [15:0]         data_norm_q, data_norm_d;
  logic                data_valid_q, data_valid_d;

  logic              w_at_end;
  logic              w_cap;
  logic [1:0]        w_sel_code;
  logic [DATA_W-1:0] w_c3;
  logic [16:0]       w_top;

  // Window counter, rate selection, settling and the three comb stages
  always_comb begin
    cnt_d        = cnt_q;
    r_act_d      = r_act_q;
    settle_d     = settle_q;
    x_reg_d      = x_reg_q;
    x_prev_d     = x_prev_q;
    c1_d         = c1_q;
    c1_prev_d    = c1_prev_q;
    c2_d         = c2_q;
    c2_prev_d    = c2_prev_q;
    cap_ok_d     = cap_ok_q;
    cap_shift_d  = cap_shift_q;
    data_raw_d   = data_raw_q;
    data_norm_d  = data_norm_q;
    data_valid_d = 1'b0;

    w_sel_code = sel_to_code(dec_sel);
    w_at_end   = (cnt_q == code_to_last(r_act_q));
    w_cap      = w_at_end & ~dec_sync;

    // The sync cycle itself is window cycle 0, so the count resumes at 1
    // and the next capture lands R-1 cycles after the sync.
    if (dec_sync) begin
      cnt_d    = 7'd1;
      r_act_d  = w_sel_code;
      settle_d = '0;
    end else if (w_at_end) begin
      cnt_d   = 7'd0;
      r_act_d = w_sel_code;
      if (w_sel_code != r_act_q) begin
        settle_d = '0;
      end else if (settle_q != SETTLE_MAX) begin
        settle_d = settle_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 7'd1;
    end

    // Tag the capture with its validity and the rate of the window it closes,
    // so a rate change at the wrap cannot affect the sample already in flight.
    if (w_cap) begin
      x_reg_d     = cn_in;
      cap_ok_d    = (settle_q == SETTLE_MAX);
      cap_shift_d = code_to_shift(r_act_q);
    end

    cap_d1_d = w_cap;
    cap_d2_d = cap_d1_q;
    cap_d3_d = cap_d2_q;

    if (cap_d1_q) begin
      c1_d     = x_reg_q - x_prev_q;
      x_prev_d = x_reg_q;
    end

    if (cap_d2_q) begin
      c2_d      = c1_q - c1_prev_q;
      c1_prev_d = c1_q;
    end

    w_c3  = c2_q - c2_prev_q;
    w_top = 17'((w_c3 << cap_shift_q) >> 5);

    if (cap_d3_q) begin
      c2_prev_d = c2_q;
      if (cap_ok_q) begin
        data_raw_d   = w_c3;
        data_norm_d  = w_top[16] ? 16'hFFFF : w_top[15:0];
        data_valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      r_act_q      <= 2'd2;
      settle_q     <= '0;
      x_reg_q      <= '0;
      x_prev_q     <= '0;
      c1_q         <= '0;
      c1_prev_q    <= '0;
      c2_q         <= '0;
      c2_prev_q    <= '0;
      cap_d1_q     <= 1'b0;
      cap_d2_q     <= 1'b0;
      cap_d3_q     <= 1'b0;
      cap_ok_q     <= 1'b0;
      cap_shift_q  <= '0;
      data_raw_q   <= '0;
      data_norm_q  <= '0;
      data_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      r_act_q      <= r_act_d;
      settle_q     <= settle_d;
      x_reg_q      <= x_reg_d;
      x_prev_q     <= x_prev_d;
      c1_q         <= c1_d;
      c1_prev_q    <= c1_prev_d;
      c2_q         <= c2_d;
      c2_prev_q    <= c2_prev_d;
      cap_d1_q     <= cap_d1_d;
      cap_d2_q     <= cap_d2_d;
      cap_d3_q     <= cap_d3_d;
      cap_ok_q     <= cap_ok_d;
      cap_shift_q  <= cap_shift_d;
      data_raw_q   <= data_raw_d;
      data_norm_q  <= data_norm_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_raw   = data_raw_q;
  assign data_norm  = data_norm_q;
  assign data_valid = data_valid_q;

endmodule
`default_nettype wire
